// File: rtl/axi_dma_ctrl_2d_pkg.sv
// axi_dma_pkg: shared channel state encoding and default parameter values for the 2D DMA controller
package axi_dma_pkg;
    localparam int DEF_AXI_WIDTH_AD = 32;
    localparam int DEF_BIT_TRANS    = 18;
    localparam int DEF_IDX_W        = 16;
    localparam int DEF_BLK_SHIFT    = 6;
    localparam int DEF_BEAT_SHIFT   = 2;
    typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_SYNC, ST_DONE} state_t;
endpackage

// File: rtl/axi_dma_ctrl_2d_if.sv
// axi_dma_ctrl_2d_if: request/done handshake between the 2D DMA controller (master) and the AXI master engine (slave)
interface axi_dma_ctrl_2d_if import axi_dma_pkg::*; #(
    parameter int AXI_WIDTH_AD = DEF_AXI_WIDTH_AD,
    parameter int BIT_TRANS    = DEF_BIT_TRANS
);
    logic                    o_ctrl_read;
    logic [AXI_WIDTH_AD-1:0] o_read_addr;
    logic                    o_ctrl_read_done;
    logic                    o_busy_rd;
    logic                    i_read_done;
    logic                    o_ctrl_write;
    logic [AXI_WIDTH_AD-1:0] o_write_addr;
    logic [BIT_TRANS-1:0]    o_write_data_cnt;
    logic                    o_ctrl_write_done;
    logic                    o_busy_wr;
    logic                    i_write_done;
    logic                    i_indata_req_wr;
    modport master (
        output o_ctrl_read, o_read_addr, o_ctrl_read_done, o_busy_rd,
        output o_ctrl_write, o_write_addr, o_write_data_cnt, o_ctrl_write_done, o_busy_wr,
        input  i_read_done, i_write_done, i_indata_req_wr
    );
    modport slave (
        input  o_ctrl_read, o_read_addr, o_ctrl_read_done, o_busy_rd,
        input  o_ctrl_write, o_write_addr, o_write_data_cnt, o_ctrl_write_done, o_busy_wr,
        output i_read_done, i_write_done, i_indata_req_wr
    );
endinterface

// File: rtl/axi_dma_ctrl_2d_seq.sv
// dma_ch_seq: one channel's block/row walk over a 2D region with latched config, abort and block address generation
module dma_ch_seq import axi_dma_pkg::*; #(
    parameter int AXI_WIDTH_AD = DEF_AXI_WIDTH_AD,
    parameter int IDX_W        = DEF_IDX_W,
    parameter int BLK_SHIFT    = DEF_BLK_SHIFT
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    i_start,
    input  logic                    i_abort,
    input  logic                    i_done,
    input  logic [AXI_WIDTH_AD-1:0] i_base,
    input  logic [AXI_WIDTH_AD-1:0] i_stride,
    input  logic [IDX_W-1:0]        i_blks,
    input  logic [IDX_W-1:0]        i_rows,
    output logic                    o_req,
    output logic                    o_seq_done,
    output state_t                  o_state,
    output logic [AXI_WIDTH_AD-1:0] o_addr
);
    state_t                  r_state;
    logic [IDX_W-1:0]        r_blks, r_rows, r_blk, r_row;
    logic [AXI_WIDTH_AD-1:0] r_stride, r_row_base;
    logic                    r_req, r_done;
    logic                    w_last_blk, w_last_row;

    assign w_last_blk = r_blk == r_blks - IDX_W'(1);
    assign w_last_row = r_row == r_rows - IDX_W'(1);

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            r_state    <= ST_IDLE;
            r_req      <= 1'b0;
            r_done     <= 1'b0;
            r_blks     <= '0;
            r_rows     <= '0;
            r_blk      <= '0;
            r_row      <= '0;
            r_stride   <= '0;
            r_row_base <= '0;
        end else if (i_abort) begin
            r_state    <= ST_IDLE;
            r_req      <= 1'b0;
            r_done     <= 1'b0;
            r_blk      <= '0;
            r_row      <= '0;
            r_row_base <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (i_start) begin
                    r_blks     <= i_blks;
                    r_rows     <= i_rows;
                    r_stride   <= i_stride;
                    r_row_base <= i_base;
                    r_blk      <= '0;
                    r_row      <= '0;
                    // an empty region completes without issuing any request
                    r_state    <= (i_blks == '0 || i_rows == '0) ? ST_DONE : ST_REQ;
                    r_done     <= i_blks == '0 || i_rows == '0;
                    r_req      <= i_blks != '0 && i_rows != '0;
                end
                ST_REQ: begin
                    r_state <= ST_WAIT;
                    r_req   <= 1'b0;
                end
                ST_WAIT: if (i_done) begin
                    if (w_last_blk && w_last_row) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= ST_SYNC;
                        r_blk   <= w_last_blk ? '0 : r_blk + IDX_W'(1);
                        if (w_last_blk) begin
                            r_row      <= r_row + IDX_W'(1);
                            r_row_base <= r_row_base + r_stride;
                        end
                    end
                end
                ST_SYNC: begin
                    r_state <= ST_REQ;
                    r_req   <= 1'b1;
                end
                ST_DONE: begin
                    r_state    <= ST_IDLE;
                    r_done     <= 1'b0;
                    r_blk      <= '0;
                    r_row      <= '0;
                    r_row_base <= '0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end

    assign o_req      = r_req;
    assign o_seq_done = r_done;
    assign o_state    = r_state;
    assign o_addr     = r_row_base + (AXI_WIDTH_AD'(r_blk) << BLK_SHIFT);
endmodule

// File: rtl/axi_dma_ctrl_2d.sv
// axi_dma_ctrl_2d: independent read/write 2D block request sequencers plus the write beat counter and beat address offset
module axi_dma_ctrl_2d import axi_dma_pkg::*; #(
    parameter int AXI_WIDTH_AD = DEF_AXI_WIDTH_AD,
    parameter int BIT_TRANS    = DEF_BIT_TRANS,
    parameter int IDX_W        = DEF_IDX_W,
    parameter int BLK_SHIFT    = DEF_BLK_SHIFT,
    parameter int BEAT_SHIFT   = DEF_BEAT_SHIFT
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    i_start_rd,
    input  logic                    i_start_wr,
    input  logic                    i_abort,
    input  logic [AXI_WIDTH_AD-1:0] i_base_addr_rd,
    input  logic [AXI_WIDTH_AD-1:0] i_base_addr_wr,
    input  logic [IDX_W-1:0]        i_blks_per_row_rd,
    input  logic [IDX_W-1:0]        i_blks_per_row_wr,
    input  logic [IDX_W-1:0]        i_num_rows_rd,
    input  logic [IDX_W-1:0]        i_num_rows_wr,
    input  logic [AXI_WIDTH_AD-1:0] i_row_stride_rd,
    input  logic [AXI_WIDTH_AD-1:0] i_row_stride_wr,
    input  logic [BIT_TRANS-1:0]    i_num_trans,
    axi_dma_ctrl_2d_if.master       bus
);
    state_t                  w_rd_state, w_wr_state;
    logic                    w_rd_req, w_rd_done, w_wr_req, w_wr_done, w_wr_acc;
    logic [AXI_WIDTH_AD-1:0] w_rd_addr, w_wr_addr;
    logic [BIT_TRANS-1:0]    r_cnt;

    dma_ch_seq #(.AXI_WIDTH_AD(AXI_WIDTH_AD), .IDX_W(IDX_W), .BLK_SHIFT(BLK_SHIFT)) u_rd (
        .clk(clk), .rstn(rstn), .i_start(i_start_rd), .i_abort(i_abort), .i_done(bus.i_read_done),
        .i_base(i_base_addr_rd), .i_stride(i_row_stride_rd), .i_blks(i_blks_per_row_rd), .i_rows(i_num_rows_rd),
        .o_req(w_rd_req), .o_seq_done(w_rd_done), .o_state(w_rd_state), .o_addr(w_rd_addr)
    );

    dma_ch_seq #(.AXI_WIDTH_AD(AXI_WIDTH_AD), .IDX_W(IDX_W), .BLK_SHIFT(BLK_SHIFT)) u_wr (
        .clk(clk), .rstn(rstn), .i_start(i_start_wr), .i_abort(i_abort), .i_done(bus.i_write_done),
        .i_base(i_base_addr_wr), .i_stride(i_row_stride_wr), .i_blks(i_blks_per_row_wr), .i_rows(i_num_rows_wr),
        .o_req(w_wr_req), .o_seq_done(w_wr_done), .o_state(w_wr_state), .o_addr(w_wr_addr)
    );

    assign w_wr_acc = w_wr_state == ST_WAIT && bus.i_write_done;

    // beat index restarts with every block; num_trans==0 pins it at zero
    always_ff @(posedge clk or negedge rstn)
        if (!rstn)
            r_cnt <= '0;
        else if (i_abort || w_wr_req || w_wr_acc || i_num_trans == '0)
            r_cnt <= '0;
        else if (bus.i_indata_req_wr)
            r_cnt <= (r_cnt == i_num_trans - BIT_TRANS'(1)) ? '0 : r_cnt + BIT_TRANS'(1);

    assign bus.o_ctrl_read       = w_rd_req;
    assign bus.o_read_addr       = w_rd_addr;
    assign bus.o_ctrl_read_done  = w_rd_done;
    assign bus.o_busy_rd         = w_rd_state != ST_IDLE;
    assign bus.o_ctrl_write      = w_wr_req;
    assign bus.o_write_addr      = w_wr_addr + (AXI_WIDTH_AD'(r_cnt) << BEAT_SHIFT);
    assign bus.o_write_data_cnt  = r_cnt;
    assign bus.o_ctrl_write_done = w_wr_done;
    assign bus.o_busy_wr         = w_wr_state != ST_IDLE;
endmodule

// File: tb/tb_axi_dma_ctrl_2d.sv
// tb_axi_dma_ctrl_2d: directed cycle-exact checks of the 2D DMA controller read/write sequences, abort and wrap cases
module tb_axi_dma_ctrl_2d;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        i_start_rd = 1'b0, i_start_wr = 1'b0, i_abort = 1'b0;
    logic [31:0] i_base_addr_rd = '0, i_base_addr_wr = '0, i_row_stride_rd = '0, i_row_stride_wr = '0;
    logic [15:0] i_blks_per_row_rd = '0, i_blks_per_row_wr = '0, i_num_rows_rd = '0, i_num_rows_wr = '0;
    logic [17:0] i_num_trans = '0;
    int          n_cmp = 0, n_err = 0;
    int          n_rdreq = 0, n_rddone = 0, n_wrreq = 0, n_wrdone = 0;

    always #5 clk = ~clk;

    axi_dma_ctrl_2d_if bus();

    axi_dma_ctrl_2d dut (
        .clk(clk), .rstn(rstn), .i_start_rd(i_start_rd), .i_start_wr(i_start_wr), .i_abort(i_abort),
        .i_base_addr_rd(i_base_addr_rd), .i_base_addr_wr(i_base_addr_wr),
        .i_blks_per_row_rd(i_blks_per_row_rd), .i_blks_per_row_wr(i_blks_per_row_wr),
        .i_num_rows_rd(i_num_rows_rd), .i_num_rows_wr(i_num_rows_wr),
        .i_row_stride_rd(i_row_stride_rd), .i_row_stride_wr(i_row_stride_wr),
        .i_num_trans(i_num_trans), .bus(bus)
    );

    always @(posedge clk) begin
        if (bus.o_ctrl_read)       n_rdreq++;
        if (bus.o_ctrl_read_done)  n_rddone++;
        if (bus.o_ctrl_write)      n_wrreq++;
        if (bus.o_ctrl_write_done) n_wrdone++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic rd_seq(input logic [31:0] base, input logic [31:0] stride, input int blks, input int rows);
        logic [31:0] exp;
        i_base_addr_rd = base; i_row_stride_rd = stride;
        i_blks_per_row_rd = 16'(blks); i_num_rows_rd = 16'(rows);
        i_start_rd = 1'b1;
        @(negedge clk);
        i_start_rd = 1'b0;
        i_base_addr_rd = 32'hDEAD_0000; i_row_stride_rd = 32'h5555; i_blks_per_row_rd = 16'd9; i_num_rows_rd = 16'd9;
        if (blks == 0 || rows == 0) begin
            check("rd_empty_done", bus.o_ctrl_read_done, 1);
            check("rd_empty_noreq", bus.o_ctrl_read, 0);
        end else begin
            for (int r = 0; r < rows; r++)
                for (int b = 0; b < blks; b++) begin
                    exp = base + 32'(r) * stride + 32'(b) * 32'd64;
                    check("rd_req", bus.o_ctrl_read, 1);
                    check("rd_addr", bus.o_read_addr, exp);
                    repeat (4) @(negedge clk);
                    check("rd_busy_wait", bus.o_busy_rd, 1);
                    bus.i_read_done = 1'b1;
                    @(negedge clk);
                    bus.i_read_done = 1'b0;
                    check("rd_done_strobe", bus.o_ctrl_read_done, (r == rows - 1 && b == blks - 1) ? 1 : 0);
                    check("rd_sync_noreq", bus.o_ctrl_read, 0);
                    if (!(r == rows - 1 && b == blks - 1)) @(negedge clk);
                end
        end
        @(negedge clk);
        check("rd_done_single", bus.o_ctrl_read_done, 0);
        check("rd_busy_end", bus.o_busy_rd, 0);
    endtask

    task automatic wr_seq(input logic [31:0] base, input logic [31:0] stride, input int blks, input int rows,
                          input int ntrans, input int nbeats);
        logic [31:0] blk_a;
        int e;
        i_base_addr_wr = base; i_row_stride_wr = stride;
        i_blks_per_row_wr = 16'(blks); i_num_rows_wr = 16'(rows); i_num_trans = 18'(ntrans);
        i_start_wr = 1'b1;
        @(negedge clk);
        i_start_wr = 1'b0;
        i_base_addr_wr = 32'hBEEF_0000; i_blks_per_row_wr = 16'd7; i_num_rows_wr = 16'd7;
        for (int r = 0; r < rows; r++)
            for (int b = 0; b < blks; b++) begin
                blk_a = base + 32'(r) * stride + 32'(b) * 32'd64;
                check("wr_req", bus.o_ctrl_write, 1);
                check("wr_addr_req", bus.o_write_addr, blk_a);
                check("wr_cnt_req", bus.o_write_data_cnt, 0);
                @(negedge clk);
                for (int k = 0; k < nbeats; k++) begin
                    e = (ntrans == 0) ? 0 : k % ntrans;
                    check("wr_cnt", bus.o_write_data_cnt, 64'(e));
                    check("wr_addr", bus.o_write_addr, blk_a + 32'(e) * 32'd4);
                    bus.i_indata_req_wr = 1'b1;
                    @(negedge clk);
                end
                bus.i_indata_req_wr = 1'b0;
                e = (ntrans == 0) ? 0 : nbeats % ntrans;
                check("wr_cnt_end", bus.o_write_data_cnt, 64'(e));
                bus.i_write_done = 1'b1;
                @(negedge clk);
                bus.i_write_done = 1'b0;
                check("wr_done_strobe", bus.o_ctrl_write_done, (r == rows - 1 && b == blks - 1) ? 1 : 0);
                check("wr_cnt_clr", bus.o_write_data_cnt, 0);
                if (!(r == rows - 1 && b == blks - 1)) @(negedge clk);
            end
        @(negedge clk);
        check("wr_done_single", bus.o_ctrl_write_done, 0);
        check("wr_busy_end", bus.o_busy_wr, 0);
    endtask

    initial begin
        int snap;
        bus.i_read_done = 1'b0; bus.i_write_done = 1'b0; bus.i_indata_req_wr = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ctrl_read", bus.o_ctrl_read, 0);
        check("rst_read_addr", bus.o_read_addr, 0);
        check("rst_busy_rd", bus.o_busy_rd, 0);
        check("rst_ctrl_write", bus.o_ctrl_write, 0);
        check("rst_write_addr", bus.o_write_addr, 0);
        check("rst_cnt", bus.o_write_data_cnt, 0);
        check("rst_busy_wr", bus.o_busy_wr, 0);
        rstn = 1'b1;
        @(negedge clk);

        snap = n_rdreq;
        rd_seq(32'h1000, 32'h400, 3, 2);
        check("rd_req_count", 64'(n_rdreq - snap), 6);

        snap = n_wrdone;
        wr_seq(32'h2000, 32'h0, 2, 1, 16, 16);
        check("wr_done_count", 64'(n_wrdone - snap), 1);

        snap = n_rdreq;
        rd_seq(32'h1000, 32'h0, 0, 1);
        rd_seq(32'h1000, 32'h0, 2, 0);
        check("rd_empty_req_count", 64'(n_rdreq - snap), 0);

        i_base_addr_rd = 32'h3000; i_row_stride_rd = 32'h0; i_blks_per_row_rd = 16'd6; i_num_rows_rd = 16'd1;
        i_start_rd = 1'b1;
        @(negedge clk);
        i_start_rd = 1'b0;
        check("ab_addr0", bus.o_read_addr, 32'h3000);
        repeat (4) @(negedge clk);
        bus.i_read_done = 1'b1;
        @(negedge clk);
        bus.i_read_done = 1'b0;
        @(negedge clk);
        check("ab_req1", bus.o_ctrl_read, 1);
        check("ab_addr1", bus.o_read_addr, 32'h3040);
        @(negedge clk);
        snap = n_rddone;
        i_abort = 1'b1;
        bus.i_read_done = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        bus.i_read_done = 1'b0;
        check("ab_busy", bus.o_busy_rd, 0);
        check("ab_no_done", bus.o_ctrl_read_done, 0);
        check("ab_addr_clr", bus.o_read_addr, 0);
        repeat (3) @(negedge clk);
        check("ab_done_count", 64'(n_rddone - snap), 0);
        i_start_rd = 1'b1;
        @(negedge clk);
        i_start_rd = 1'b0;
        check("ab_restart_req", bus.o_ctrl_read, 1);
        check("ab_restart_addr", bus.o_read_addr, 32'h3000);
        @(negedge clk);
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        check("ab2_busy", bus.o_busy_rd, 0);
        i_abort = 1'b1;
        i_start_rd = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        i_start_rd = 1'b0;
        check("ab_over_start", bus.o_busy_rd, 0);
        @(negedge clk);
        check("ab_over_start_noreq", bus.o_ctrl_read, 0);

        fork
            rd_seq(32'h5000, 32'h100, 4, 1);
            wr_seq(32'h6000, 32'h0, 2, 1, 4, 6);
        join
        bus.i_read_done = 1'b1;
        @(negedge clk);
        bus.i_read_done = 1'b0;
        check("spur_busy", bus.o_busy_rd, 0);
        check("spur_noreq", bus.o_ctrl_read, 0);
        check("spur_addr", bus.o_read_addr, 0);

        wr_seq(32'h7000, 32'h0, 1, 1, 0, 3);
        rd_seq(32'hFFFF_FFC0, 32'h0, 2, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/axi_dma_ctrl_2d.md
Name: axi_dma_ctrl_2d

Overview:
Parametrised successor DMA control FSM generating block-wise read and write request sequences over a 2D region (rows × blocks-per-row, programmable row stride). Read and write channels are fully independent. Both channels latch their configuration at start and support abort. Control only: it drives request/address toward the AXI master and consumes its done/beat-request strobes, with no AXI signalling itself.

Parameters:
AXI_WIDTH_AD, 32, address width
BIT_TRANS, 18, width of beat counter / num_trans
IDX_W, 16, width of block and row counters
BLK_SHIFT, 6, log2 bytes per block request (64 B)
BEAT_SHIFT, 2, log2 bytes per write beat (4 B)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
i_start_rd  in  1  read start pulse; sampled only in IDLE
i_start_wr  in  1  write start pulse; sampled only in IDLE
i_abort  in  1  abort both channels
i_base_addr_rd / i_base_addr_wr  in  AXI_WIDTH_AD  region base address
i_blks_per_row_rd / i_blks_per_row_wr  in  IDX_W  blocks per row
i_num_rows_rd / i_num_rows_wr  in  IDX_W  row count
i_row_stride_rd / i_row_stride_wr  in  AXI_WIDTH_AD  byte stride between rows
i_num_trans  in  BIT_TRANS  write beats per block
i_read_done  in  1  current read block complete
o_ctrl_read  out  1  one-cycle read request
o_read_addr  out  AXI_WIDTH_AD  read block address
o_ctrl_read_done  out  1  one-cycle read sequence complete
o_busy_rd  out  1  read channel not IDLE
i_write_done  in  1  current write block complete
i_indata_req_wr  in  1  master consumed one write beat
o_ctrl_write  out  1  one-cycle write request
o_write_addr  out  AXI_WIDTH_AD  write beat address
o_write_data_cnt  out  BIT_TRANS  beat index within block
o_ctrl_write_done  out  1  one-cycle write sequence complete
o_busy_wr  out  1  write channel not IDLE

Behaviour:
- Reset: all outputs 0, both FSMs in IDLE, all counters and latched config cleared.
- Per-channel FSM states and transitions:
  - IDLE → REQ on start. Config (base, blks, rows, stride) is latched on the same edge.
  - REQ (ctrl=1) → WAIT.
  - WAIT → SYNC on done when not on the last block; → DONE on done for the last block (row==rows-1 and blk==blks-1).
  - SYNC → REQ.
  - DONE (done pulse) → IDLE.
- Timing: start sampled at cycle 0 → ctrl high at cycle 1. Done in WAIT at cycle N → next ctrl at N+2, or done pulse at N+1.
- Counters: blk_idx increments on accepted done. At blks-1 it wraps to 0, row_idx increments and row_base += stride. No multiplier is used.
- Address: addr = row_base + (blk_idx << BLK_SHIFT), all modulo 2^AXI_WIDTH_AD. row_base is loaded with base at start.
- Write address additionally adds (write_data_cnt << BEAT_SHIFT).
- write_data_cnt:
  - clears on o_ctrl_write or on accepted write_done;
  - otherwise increments on i_indata_req_wr, wrapping num_trans-1 → 0;
  - num_trans==0 holds it at 0.
- done strobes outside WAIT are ignored and do not change counters.
- blks==0 or rows==0: IDLE → DONE directly. Done pulse at cycle 1, no request issued.
- start while busy is ignored. Read and write run concurrently with no interaction.
- i_abort: every non-IDLE channel → IDLE next cycle, no done pulse, counters cleared. Abort takes priority over start and done in the same cycle.
- Config inputs may change freely after start; only the latched copies are used.

Decomposition:
- Package axi_dma_pkg: state enum (ST_IDLE, ST_REQ, ST_WAIT, ST_SYNC, ST_DONE), default parameter constants.
- Sub-module dma_ch_seq: FSM, blk/row counters, row_base, address. Instantiated twice (rd, wr).
- Top adds the write beat counter and the write address offset.

Test Plan:
- Read, base=0x1000, blks=3, rows=2, stride=0x400, done 4 cycles after each request → addresses 0x1000, 0x1040, 0x1080, 0x1400, 0x1440, 0x1480; single o_ctrl_read_done; busy low after.
- Write, base=0x2000, blks=2, rows=1, num_trans=16, 16 indata_req each block → o_write_addr steps 0x2000..0x203C then 0x2040..0x207C; cnt wraps 15→0; o_ctrl_write_done once.
- blks=0, start_rd → o_ctrl_read_done at cycle 1, no o_ctrl_read.
- Abort in WAIT of block 2 of 6 → IDLE next cycle, no done pulse. Restart begins at base again.
- Concurrent read (blks=4) and write (blks=2) started the same cycle → both sequences correct and independent; a spurious i_read_done while IDLE changes nothing.
- Base=0xFFFF_FFC0, blks=2 → second address wraps to 0x0000_0000.
